// File: rtl/regfile_writeback_unit_if.sv
// Bus bundle between the execute/memory stages, the issue logic and the
// register file write port of regfile_writeback_unit.
// master : upstream/issue side that drives loads, responses, ALU results and queries
// slave  : the writeback unit itself
interface regfile_writeback_unit_if #(
   parameter int AW = 5,
   parameter int DW = 32
);
   // Load issue handshake
   logic          load_issue_valid;
   logic          load_issue_ready;
   logic [AW-1:0] load_issue_rd;
   logic [3:0]    load_issue_width;
   logic          load_issue_unsigned;
   logic [1:0]    load_issue_offset;

   // Memory response (no backpressure)
   logic          mem_resp_valid;
   logic [DW-1:0] mem_resp_data;

   // ALU writeback handshake
   logic          alu_wb_valid;
   logic          alu_wb_ready;
   logic [AW-1:0] alu_wb_rd;
   logic [DW-1:0] alu_wb_data;

   // Scoreboard queries
   logic [AW-1:0] query_rs1_addr;
   logic [AW-1:0] query_rs2_addr;
   logic [AW-1:0] query_rd_addr;
   logic          rs1_pending;
   logic          rs2_pending;
   logic          rd_pending;

   // Register file write port
   logic          write_enable;
   logic [3:0]    write_width;
   logic [AW-1:0] write_reg_addr;
   logic [DW-1:0] write_data;

   // Sticky error flag
   logic          resp_underflow;

   modport master (
      output load_issue_valid, load_issue_rd, load_issue_width,
             load_issue_unsigned, load_issue_offset,
             mem_resp_valid, mem_resp_data,
             alu_wb_valid, alu_wb_rd, alu_wb_data,
             query_rs1_addr, query_rs2_addr, query_rd_addr,
      input  load_issue_ready, alu_wb_ready,
             rs1_pending, rs2_pending, rd_pending,
             write_enable, write_width, write_reg_addr, write_data,
             resp_underflow
   );

   modport slave (
      input  load_issue_valid, load_issue_rd, load_issue_width,
             load_issue_unsigned, load_issue_offset,
             mem_resp_valid, mem_resp_data,
             alu_wb_valid, alu_wb_rd, alu_wb_data,
             query_rs1_addr, query_rs2_addr, query_rd_addr,
      output load_issue_ready, alu_wb_ready,
             rs1_pending, rs2_pending, rd_pending,
             write_enable, write_width, write_reg_addr, write_data,
             resp_underflow
   );
endinterface

// File: rtl/regfile_writeback_unit.sv
// Register file writeback unit: sole driver of the register file write port.
// Merges ALU results with in-order, variable-latency load responses, aligns and
// extends load data, and tracks outstanding loads per destination register so
// issue logic can detect RAW/WAW hazards.
module regfile_writeback_unit #(
   parameter int REG_NUMBER       = 32,
   parameter int REG_ADDR_WIDTH   = $clog2(REG_NUMBER),
   parameter int REG_WIDTH_IN_BIT = 32,
   parameter int LOAD_DEPTH       = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   regfile_writeback_unit_if.slave   bus
);

   localparam int PTR_W = $clog2(LOAD_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // One outstanding load: where it goes and how to format its data.
   typedef struct packed {
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic [3:0]                width;
      logic                      is_unsigned;
      logic [1:0]                offset;
   } load_entry_t;

   load_entry_t                 r_queue [LOAD_DEPTH];
   logic [PTR_W-1:0]            r_wr_ptr;
   logic [PTR_W-1:0]            r_rd_ptr;
   logic [CNT_W-1:0]            r_count;
   logic [REG_NUMBER-1:0]       r_pending;

   logic                        r_write_enable;
   logic [3:0]                  r_write_width;
   logic [REG_ADDR_WIDTH-1:0]   r_write_reg_addr;
   logic [REG_WIDTH_IN_BIT-1:0] r_write_data;
   logic                        r_resp_underflow;

   logic                        w_full;
   logic                        w_empty;
   logic                        w_issue_waw;
   logic                        w_issue_ready;
   logic                        w_push;
   logic                        w_pop;
   logic                        w_alu_accept;
   load_entry_t                 w_head;
   load_entry_t                 w_new_entry;
   logic [REG_NUMBER-1:0]       w_pending_next;
   logic [7:0]                  w_byte_lane;
   logic [15:0]                 w_half_lane;
   logic [REG_WIDTH_IN_BIT-1:0] w_load_data;
   logic [3:0]                  w_load_width;

   assign w_full  = (r_count == CNT_W'(LOAD_DEPTH));
   assign w_empty = (r_count == '0);

   // A second load to a register that still waits for data would reorder the
   // writes, so it is stalled until the older response has popped; there is
   // deliberately no bypass from a same-cycle pop.
   assign w_issue_waw   = r_pending[bus.load_issue_rd] & (bus.load_issue_rd != '0);
   assign w_issue_ready = ~w_full & ~w_issue_waw;

   assign w_push       = bus.load_issue_valid & w_issue_ready;
   assign w_pop        = bus.mem_resp_valid & ~w_empty;
   // Load responses cannot be back-pressured, so they always take the port.
   assign w_alu_accept = bus.alu_wb_valid & ~bus.mem_resp_valid;

   assign w_head      = r_queue[r_rd_ptr];
   assign w_new_entry = '{rd:          bus.load_issue_rd,
                          width:       bus.load_issue_width,
                          is_unsigned: bus.load_issue_unsigned,
                          offset:      bus.load_issue_offset};

   assign bus.load_issue_ready = w_issue_ready;
   assign bus.alu_wb_ready     = ~bus.mem_resp_valid;

   // Register 0 never holds a pending load, so its query is forced low.
   assign bus.rs1_pending = r_pending[bus.query_rs1_addr] & (bus.query_rs1_addr != '0);
   assign bus.rs2_pending = r_pending[bus.query_rs2_addr] & (bus.query_rs2_addr != '0);
   assign bus.rd_pending  = r_pending[bus.query_rd_addr]  & (bus.query_rd_addr  != '0);

   assign bus.write_enable   = r_write_enable;
   assign bus.write_width    = r_write_width;
   assign bus.write_reg_addr = r_write_reg_addr;
   assign bus.write_data     = r_write_data;
   assign bus.resp_underflow = r_resp_underflow;

   // Store a newly issued load at the tail of the queue.
   // NOTE: queue storage has no reset; validity is carried by r_count, so the
   // entries never need a known value and stay plain flops without a reset net.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_queue[r_wr_ptr] <= w_new_entry;
      end
   end

   // Advance the wrapping queue pointers and the occupancy count.
   // NOTE: sequential state is always assigned with <= so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Next scoreboard state: clear the popped load's register, mark the pushed one.
   // NOTE: combinational blocks start from a full default so no path leaves a
   // bit unassigned, which would otherwise infer a latch.
   always_comb begin
      w_pending_next = r_pending;
      if (w_pop) begin
         w_pending_next[w_head.rd] = 1'b0;
      end
      if (w_push && (bus.load_issue_rd != '0)) begin
         w_pending_next[bus.load_issue_rd] = 1'b1;
      end
   end

   // Scoreboard flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pending <= '0;
      end else begin
         r_pending <= w_pending_next;
      end
   end

   // Pick the addressed byte/half lane; equivalent to shifting the word right
   // by 8*offset and keeping the low bits. Halves only look at offset[1].
   always_comb begin
      w_byte_lane = bus.mem_resp_data[7:0];
      case (w_head.offset)
         2'd0: w_byte_lane = bus.mem_resp_data[7:0];
         2'd1: w_byte_lane = bus.mem_resp_data[15:8];
         2'd2: w_byte_lane = bus.mem_resp_data[23:16];
         2'd3: w_byte_lane = bus.mem_resp_data[31:24];
         default: w_byte_lane = bus.mem_resp_data[7:0];
      endcase
      w_half_lane = w_head.offset[1] ? bus.mem_resp_data[31:16] : bus.mem_resp_data[15:0];
   end

   // Extend the selected lane and choose the write width. Signed sub-word
   // loads become full 32-bit writes; unsigned ones write only the lane.
   always_comb begin
      w_load_data  = bus.mem_resp_data;
      w_load_width = 4'd4;
      case (w_head.width)
         4'd1: begin
            if (w_head.is_unsigned) begin
               w_load_data  = {24'b0, w_byte_lane};
               w_load_width = 4'd1;
            end else begin
               w_load_data  = {{24{w_byte_lane[7]}}, w_byte_lane};
               w_load_width = 4'd4;
            end
         end
         4'd2: begin
            if (w_head.is_unsigned) begin
               w_load_data  = {16'b0, w_half_lane};
               w_load_width = 4'd2;
            end else begin
               w_load_data  = {{16{w_half_lane[15]}}, w_half_lane};
               w_load_width = 4'd4;
            end
         end
         default: begin
            w_load_data  = bus.mem_resp_data;
            w_load_width = 4'd4;
         end
      endcase
   end

   // Register file write port: one cycle after the winning source is accepted.
   // Address, width and data hold when nothing is written.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_write_enable   <= 1'b0;
         r_write_width    <= 4'd4;
         r_write_reg_addr <= '0;
         r_write_data     <= '0;
      end else if (w_pop) begin
         r_write_enable   <= 1'b1;
         r_write_width    <= w_load_width;
         r_write_reg_addr <= w_head.rd;
         r_write_data     <= w_load_data;
      end else if (w_alu_accept) begin
         r_write_enable   <= 1'b1;
         r_write_width    <= 4'd4;
         r_write_reg_addr <= bus.alu_wb_rd;
         r_write_data     <= bus.alu_wb_data;
      end else begin
         r_write_enable   <= 1'b0;
      end
   end

   // Sticky flag: a response arrived with nothing outstanding.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_resp_underflow <= 1'b0;
      end else if (bus.mem_resp_valid && w_empty) begin
         r_resp_underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Directed testbench for regfile_writeback_unit: reset behaviour, load
// formatting, arbitration, queue full/WAW stalls, rd=0 loads and underflow.
module tb_regfile_writeback_unit;

   localparam int AW = 5;

   logic clk;
   logic reset_n;
   int   n_total;
   int   n_bad;

   regfile_writeback_unit_if #(.AW(AW), .DW(32)) bus ();

   regfile_writeback_unit #(
      .REG_NUMBER(32),
      .REG_ADDR_WIDTH(AW),
      .REG_WIDTH_IN_BIT(32),
      .LOAD_DEPTH(4)
   ) u_dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Return 1 time unit after the next rising edge: registered outputs are
   // settled and new inputs can be driven away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.load_issue_valid    = 1'b0;
      bus.load_issue_rd       = '0;
      bus.load_issue_width    = 4'd4;
      bus.load_issue_unsigned = 1'b0;
      bus.load_issue_offset   = 2'd0;
      bus.mem_resp_valid      = 1'b0;
      bus.mem_resp_data       = '0;
      bus.alu_wb_valid        = 1'b0;
      bus.alu_wb_rd           = '0;
      bus.alu_wb_data         = '0;
      bus.query_rs1_addr      = '0;
      bus.query_rs2_addr      = '0;
      bus.query_rd_addr       = '0;
   endtask

   task automatic set_issue(input logic [AW-1:0] rd, input logic [3:0] width,
                            input logic uns, input logic [1:0] offset);
      bus.load_issue_valid    = 1'b1;
      bus.load_issue_rd       = rd;
      bus.load_issue_width    = width;
      bus.load_issue_unsigned = uns;
      bus.load_issue_offset   = offset;
   endtask

   task automatic check_write(input string tag, input logic [AW-1:0] addr,
                              input logic [3:0] width, input logic [31:0] data);
      check({tag, "_we"},    32'(bus.write_enable),   32'd1);
      check({tag, "_addr"},  32'(bus.write_reg_addr), 32'(addr));
      check({tag, "_width"}, 32'(bus.write_width),    32'(width));
      check({tag, "_data"},  bus.write_data,          data);
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      reset_n = 1'b0;
      idle_inputs();
      step();
      step();
      reset_n = 1'b1;
      step();

      // ---- 1: reset with loads queued and a write on the port ----
      set_issue(5'd9, 4'd4, 1'b0, 2'd0);
      step();
      set_issue(5'd10, 4'd4, 1'b0, 2'd0);
      step();
      bus.load_issue_valid = 1'b0;
      bus.alu_wb_valid     = 1'b1;
      bus.alu_wb_rd        = 5'd2;
      bus.alu_wb_data      = 32'h0000_0055;
      bus.query_rs1_addr   = 5'd9;
      #1;
      check("pre_rst_rs1_pending", 32'(bus.rs1_pending), 32'd1);
      step();
      bus.alu_wb_valid = 1'b0;
      check_write("pre_rst_alu", 5'd2, 4'd4, 32'h0000_0055);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_we",          32'(bus.write_enable),     32'd0);
      check("rst_width",       32'(bus.write_width),      32'd4);
      check("rst_addr",        32'(bus.write_reg_addr),   32'd0);
      check("rst_data",        bus.write_data,            32'd0);
      check("rst_underflow",   32'(bus.resp_underflow),   32'd0);
      check("rst_ready",       32'(bus.load_issue_ready), 32'd1);
      check("rst_rs1_pending", 32'(bus.rs1_pending),      32'd0);
      step();
      reset_n = 1'b1;
      step();
      // Queue must be empty after reset: a response now is an underflow.
      bus.mem_resp_valid = 1'b1;
      step();
      bus.mem_resp_valid = 1'b0;
      check("rst_queue_empty_we", 32'(bus.write_enable),   32'd0);
      check("rst_queue_empty_uf", 32'(bus.resp_underflow), 32'd1);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      step();

      // ---- 2: byte signed, offset 2 ----
      set_issue(5'd5, 4'd1, 1'b0, 2'd2);
      #1;
      check("t2_ready", 32'(bus.load_issue_ready), 32'd1);
      step();
      bus.load_issue_valid = 1'b0;
      bus.query_rs1_addr   = 5'd5;
      #1;
      check("t2_rs1_pending_set", 32'(bus.rs1_pending),  32'd1);
      check("t2_no_write_yet",    32'(bus.write_enable), 32'd0);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'h0080_0000;
      #1;
      check("t2_alu_ready_low", 32'(bus.alu_wb_ready), 32'd0);
      step();
      bus.mem_resp_valid = 1'b0;
      check_write("t2", 5'd5, 4'd4, 32'hFFFF_FF80);
      check("t2_rs1_pending_clr", 32'(bus.rs1_pending), 32'd0);
      step();
      check("t2_we_idle",   32'(bus.write_enable), 32'd0);
      check("t2_data_hold", bus.write_data,        32'hFFFF_FF80);

      // ---- 3: half unsigned, offset 2 ----
      set_issue(5'd6, 4'd2, 1'b1, 2'd2);
      step();
      bus.load_issue_valid = 1'b0;
      bus.mem_resp_valid   = 1'b1;
      bus.mem_resp_data    = 32'hBEEF_1234;
      step();
      bus.mem_resp_valid = 1'b0;
      check_write("t3", 5'd6, 4'd2, 32'h0000_BEEF);

      // Extra formatting vectors: byte unsigned offset 1, half signed offset 0
      set_issue(5'd4, 4'd1, 1'b1, 2'd1);
      step();
      set_issue(5'd8, 4'd2, 1'b0, 2'd0);
      step();
      bus.load_issue_valid = 1'b0;
      bus.mem_resp_valid   = 1'b1;
      bus.mem_resp_data    = 32'h1122_A3C4;
      step();
      check_write("t3_bu_off1", 5'd4, 4'd1, 32'h0000_00A3);
      bus.mem_resp_data = 32'h0000_8001;
      step();
      bus.mem_resp_valid = 1'b0;
      check_write("t3_hs_off0", 5'd8, 4'd4, 32'hFFFF_8001);

      // ---- 4: ALU and load response in the same cycle ----
      set_issue(5'd3, 4'd4, 1'b0, 2'd0);
      step();
      bus.load_issue_valid = 1'b0;
      bus.alu_wb_valid     = 1'b1;
      bus.alu_wb_rd        = 5'd7;
      bus.alu_wb_data      = 32'h0000_0011;
      bus.mem_resp_valid   = 1'b1;
      bus.mem_resp_data    = 32'hCAFE_F00D;
      #1;
      check("t4_alu_ready_low", 32'(bus.alu_wb_ready), 32'd0);
      step();
      bus.mem_resp_valid = 1'b0;
      check_write("t4_load", 5'd3, 4'd4, 32'hCAFE_F00D);
      #1;
      check("t4_alu_ready_high", 32'(bus.alu_wb_ready), 32'd1);
      step();
      bus.alu_wb_valid = 1'b0;
      check_write("t4_alu", 5'd7, 4'd4, 32'h0000_0011);

      // ---- 5: fill the queue, push+pop at depth, WAW stall ----
      for (int i = 0; i < 4; i++) begin
         set_issue(AW'(11 + i), 4'd4, 1'b0, 2'd0);
         #1;
         check("t5_fill_ready", 32'(bus.load_issue_ready), 32'd1);
         step();
      end
      set_issue(5'd15, 4'd4, 1'b0, 2'd0);
      #1;
      check("t5_full_ready", 32'(bus.load_issue_ready), 32'd0);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'h1111_0000;
      #1;
      check("t5_full_pop_ready", 32'(bus.load_issue_ready), 32'd0);
      step();
      check_write("t5_pop11", 5'd11, 4'd4, 32'h1111_0000);
      bus.mem_resp_data = 32'h1212_0000;
      #1;
      check("t5_pushpop_ready", 32'(bus.load_issue_ready), 32'd1);
      step();
      check_write("t5_pop12", 5'd12, 4'd4, 32'h1212_0000);
      bus.mem_resp_valid = 1'b0;
      set_issue(5'd16, 4'd4, 1'b0, 2'd0);
      #1;
      check("t5_three_ready", 32'(bus.load_issue_ready), 32'd1);
      step();
      set_issue(5'd17, 4'd4, 1'b0, 2'd0);
      #1;
      check("t5_refull_ready", 32'(bus.load_issue_ready), 32'd0);
      bus.load_issue_valid = 1'b0;
      bus.mem_resp_valid   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.mem_resp_data = 32'hD000_0000 + 32'(i);
         step();
         check_write("t5_drain", AW'(13 + i), 4'd4, 32'hD000_0000 + 32'(i));
      end
      bus.mem_resp_valid = 1'b0;

      set_issue(5'd20, 4'd4, 1'b0, 2'd0);
      step();
      bus.query_rd_addr = 5'd20;
      #1;
      check("t5_rd_pending",   32'(bus.rd_pending),       32'd1);
      check("t5_waw_ready",    32'(bus.load_issue_ready), 32'd0);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'h0000_ABCD;
      #1;
      check("t5_waw_no_bypass", 32'(bus.load_issue_ready), 32'd0);
      step();
      bus.mem_resp_valid = 1'b0;
      check_write("t5_waw_first", 5'd20, 4'd4, 32'h0000_ABCD);
      #1;
      check("t5_waw_released", 32'(bus.load_issue_ready), 32'd1);
      step();
      bus.load_issue_valid = 1'b0;
      bus.mem_resp_valid   = 1'b1;
      bus.mem_resp_data    = 32'h0000_0099;
      step();
      bus.mem_resp_valid = 1'b0;
      check_write("t5_waw_second", 5'd20, 4'd4, 32'h0000_0099);

      // rd=0 loads: queued, no pending bit, still written
      set_issue(5'd0, 4'd4, 1'b0, 2'd0);
      step();
      #1;
      check("t5_rd0_ready", 32'(bus.load_issue_ready), 32'd1);
      step();
      bus.load_issue_valid = 1'b0;
      bus.query_rs2_addr   = 5'd0;
      #1;
      check("t5_rd0_pending", 32'(bus.rs2_pending), 32'd0);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'h0000_0077;
      step();
      check_write("t5_rd0_a", 5'd0, 4'd4, 32'h0000_0077);
      step();
      bus.mem_resp_valid = 1'b0;
      check_write("t5_rd0_b", 5'd0, 4'd4, 32'h0000_0077);

      // ---- 6: response with empty queue ----
      check("t6_uf_before", 32'(bus.resp_underflow), 32'd0);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'h5555_5555;
      bus.alu_wb_valid   = 1'b1;
      bus.alu_wb_rd      = 5'd8;
      bus.alu_wb_data    = 32'h0000_0088;
      #1;
      check("t6_alu_ready_low", 32'(bus.alu_wb_ready), 32'd0);
      step();
      bus.mem_resp_valid = 1'b0;
      check("t6_no_write", 32'(bus.write_enable),   32'd0);
      check("t6_uf_set",   32'(bus.resp_underflow), 32'd1);
      step();
      bus.alu_wb_valid = 1'b0;
      check_write("t6_alu_after", 5'd8, 4'd4, 32'h0000_0088);
      step();
      step();
      check("t6_uf_sticky", 32'(bus.resp_underflow), 32'd1);
      check("t6_we_idle",   32'(bus.write_enable),   32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
